// File: rtl/hamm_pkg.sv
// Shared constants and helpers for the 12-bit SECDED Hamming code (8 data bits).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hamm_pkg;

   localparam int CODE_WIDTH = 12;
   localparam int SYN_WIDTH  = 4;
   localparam int NUM_DATA   = 8;

   // Parity bits live at code positions 1, 2, 4, 8.
   localparam int PAR_IDX [4] = '{0, 1, 3, 7};
   // D[i] lives at code index DATA_IDX[i] (positions 3,5,6,7,9,10,11,12).
   localparam int DATA_IDX [NUM_DATA] = '{2, 4, 5, 6, 8, 9, 10, 11};

   typedef enum logic [1:0] {
      CLEAN = 2'd0,
      SEC   = 2'd1,
      DED   = 2'd2
   } status_e;

   function automatic logic [NUM_DATA-1:0] extract_data(input logic [CODE_WIDTH-1:0] code);
      logic [NUM_DATA-1:0] d;
      d = '0;
      for (int i = 0; i < NUM_DATA; i++) begin
         d[i] = code[DATA_IDX[i]];
      end
      return d;
   endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// Combinational syndrome and overall-parity-mismatch generator for the 12-bit code.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: code_i  received codeword (index i = position i+1)
//        parity_i received overall parity bit
//        syn_o   syndrome, bit k = XOR of bits whose position has bit k set
//        pmis_o  overall parity mismatch (XOR of codeword and parity bit)
module hamm_syndrome
   import hamm_pkg::*;
(
   input  logic [CODE_WIDTH-1:0] code_i,
   input  logic                  parity_i,
   output logic [SYN_WIDTH-1:0]  syn_o,
   output logic                  pmis_o
);

   always_comb begin
      syn_o = '0;
      for (int i = 0; i < CODE_WIDTH; i++) begin
         for (int k = 0; k < SYN_WIDTH; k++) begin
            if ((((i + 1) >> k) & 1) != 0) begin
               syn_o[k] = syn_o[k] ^ code_i[i];
            end
         end
      end
      pmis_o = (^code_i) ^ parity_i;
   end

endmodule

// File: rtl/hamm_dec.sv
// SECDED decoder: 12-bit Hamming codeword + overall parity -> 8-bit data, with
// error flags and saturating link-health counters.
// Latency: 2 cycles, 1 word/cycle. Backpressure: out_valid && !out_ready freezes
// both stages and drops in_ready.
// Ports: HAMM_IN/PARITY_IN/in_valid/in_ready  upstream valid/ready side
//        OUT/sec_err/ded_err/syndrome/out_valid/out_ready  downstream side
//        clr_cnt, cnt_sec, cnt_ded  synchronous counter clear and counter values
module hamm_dec
   import hamm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CODE_WIDTH-1:0] HAMM_IN,
   input  logic                  PARITY_IN,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] OUT,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sec_err,
   output logic                  ded_err,
   output logic [SYN_WIDTH-1:0]  syndrome,
   input  logic                  clr_cnt,
   output logic [CNT_WIDTH-1:0]  cnt_sec,
   output logic [CNT_WIDTH-1:0]  cnt_ded
);

   // The code geometry only supports 8 data bits.
   if (DATA_WIDTH != 8) begin : g_width_check
      $error("hamm_dec: DATA_WIDTH must be 8");
   end

   logic                  enable;
   logic [SYN_WIDTH-1:0]  syn_w;
   logic                  pmis_w;

   logic                  s1_vld_q;
   logic [CODE_WIDTH-1:0] s1_code_q;
   logic [SYN_WIDTH-1:0]  s1_syn_q;
   logic                  s1_pmis_q;

   status_e               status_d;
   logic [CODE_WIDTH-1:0] fix_code_d;

   logic                  out_vld_q;
   logic [DATA_WIDTH-1:0] out_dat_q;
   logic                  sec_q;
   logic                  ded_q;
   logic [SYN_WIDTH-1:0]  syn_q;

   logic                  hs;
   logic [CNT_WIDTH-1:0]  cnt_sec_q, cnt_sec_d;
   logic [CNT_WIDTH-1:0]  cnt_ded_q, cnt_ded_d;

   assign enable   = !out_vld_q || out_ready;
   assign in_ready = enable;
   assign hs       = out_vld_q && out_ready;

   hamm_syndrome u_syn (
      .code_i   (HAMM_IN),
      .parity_i (PARITY_IN),
      .syn_o    (syn_w),
      .pmis_o   (pmis_w)
   );

   // Stage 1: capture codeword and its syndrome.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_code_q <= '0;
         s1_syn_q  <= '0;
         s1_pmis_q <= 1'b0;
      end else if (enable) begin
         s1_vld_q <= in_valid;
         if (in_valid) begin
            s1_code_q <= HAMM_IN;
            s1_syn_q  <= syn_w;
            s1_pmis_q <= pmis_w;
         end
      end
   end

   // Classification. A nonzero syndrome with matching overall parity means an
   // even number of flips; syndromes 13..15 point outside the codeword.
   always_comb begin
      status_d   = CLEAN;
      fix_code_d = s1_code_q;
      if (s1_syn_q == '0) begin
         status_d = s1_pmis_q ? SEC : CLEAN;
      end else if (!s1_pmis_q) begin
         status_d = DED;
      end else if (s1_syn_q <= 4'd12) begin
         status_d   = SEC;
         fix_code_d = s1_code_q ^ (CODE_WIDTH'(1) << (s1_syn_q - 4'd1));
      end else begin
         status_d = DED;
      end
   end

   // Stage 2: result register; payload only loads for real words so bubbles
   // leave the last result in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
         sec_q     <= 1'b0;
         ded_q     <= 1'b0;
         syn_q     <= '0;
      end else if (enable) begin
         out_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            out_dat_q <= extract_data(fix_code_d);
            sec_q     <= (status_d == SEC);
            ded_q     <= (status_d == DED);
            syn_q     <= s1_syn_q;
         end
      end
   end

   // Saturating counters; clear has priority over an increment.
   always_comb begin
      cnt_sec_d = cnt_sec_q;
      cnt_ded_d = cnt_ded_q;
      if (clr_cnt) begin
         cnt_sec_d = '0;
         cnt_ded_d = '0;
      end else if (hs) begin
         if (sec_q && (cnt_sec_q != '1)) cnt_sec_d = cnt_sec_q + 1'b1;
         if (ded_q && (cnt_ded_q != '1)) cnt_ded_d = cnt_ded_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_sec_q <= '0;
         cnt_ded_q <= '0;
      end else begin
         cnt_sec_q <= cnt_sec_d;
         cnt_ded_q <= cnt_ded_d;
      end
   end

   assign out_valid = out_vld_q;
   assign OUT       = out_dat_q;
   assign sec_err   = sec_q;
   assign ded_err   = ded_q;
   assign syndrome  = syn_q;
   assign cnt_sec   = cnt_sec_q;
   assign cnt_ded   = cnt_ded_q;

endmodule

// File: tb/tb_hamm_dec.sv
// Self-checking bench for hamm_dec: directed vectors plus randomized traffic
// with injected 0/1/2-bit errors, random backpressure and counter clears.
// Expected results come from the injected error pattern, not from decoding.
module tb_hamm_dec;

   typedef struct packed {
      logic [7:0] dat;
      logic       sec;
      logic       ded;
      logic [3:0] syn;
   } exp_t;

   localparam int MAXC = 65535;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] HAMM_IN;
   logic        PARITY_IN;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  OUT;
   logic        out_valid;
   logic        out_ready;
   logic        sec_err;
   logic        ded_err;
   logic [3:0]  syndrome;
   logic        clr_cnt;
   logic [15:0] cnt_sec;
   logic [15:0] cnt_ded;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   exp_t cur_exp;
   bit   rand_mode = 0;

   // monitor state
   int         m_sec, m_ded;
   exp_t       mon_e;
   bit         stall_prev;
   logic [7:0] sv_out;
   logic       sv_sec, sv_ded;
   logic [3:0] sv_syn;

   hamm_dec #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .HAMM_IN   (HAMM_IN),
      .PARITY_IN (PARITY_IN),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .OUT       (OUT),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sec_err   (sec_err),
      .ded_err   (ded_err),
      .syndrome  (syndrome),
      .clr_cnt   (clr_cnt),
      .cnt_sec   (cnt_sec),
      .cnt_ded   (cnt_ded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // Scatter data into non-power-of-two positions, then set the parity
   // positions so that the XOR of all set-bit positions becomes zero.
   function automatic logic [11:0] m_encode(input logic [7:0] d);
      logic [11:0] c;
      int j, s;
      c = '0; j = 0; s = 0;
      for (int p = 1; p <= 12; p++) begin
         if (!is_pow2(p)) begin
            c[p-1] = d[j];
            j++;
         end
      end
      for (int p = 1; p <= 12; p++) if (c[p-1]) s = s ^ p;
      for (int k = 0; k < 4; k++) if (s[k]) c[(1 << k) - 1] = 1'b1;
      return c;
   endfunction

   function automatic logic [7:0] m_extract(input logic [11:0] c);
      logic [7:0] d;
      int j;
      d = '0; j = 0;
      for (int p = 1; p <= 12; p++) begin
         if (!is_pow2(p)) begin
            d[j] = c[p-1];
            j++;
         end
      end
      return d;
   endfunction

   function automatic exp_t mk(input logic [7:0] d, input logic s, input logic dd,
                               input logic [3:0] sy);
      exp_t e;
      e.dat = d; e.sec = s; e.ded = dd; e.syn = sy;
      return e;
   endfunction

   // Error position 0 stands for the overall parity bit, 1..12 for code bits.
   task automatic gen_rand(output logic [11:0] c, output logic p, output exp_t e);
      logic [7:0] d;
      int nerr, e1, e2, sy;
      d    = 8'($urandom);
      c    = m_encode(d);
      p    = ^c;
      nerr = int'($urandom_range(0, 2));
      e1   = int'($urandom_range(0, 12));
      do e2 = int'($urandom_range(0, 12)); while (e2 == e1);
      sy = 0;
      if (nerr >= 1) begin
         if (e1 == 0) p = ~p; else c[e1-1] = ~c[e1-1];
         sy = sy ^ e1;
      end
      if (nerr == 2) begin
         if (e2 == 0) p = ~p; else c[e2-1] = ~c[e2-1];
         sy = sy ^ e2;
      end
      e = mk((nerr == 2) ? m_extract(c) : d, nerr == 1, nerr == 2, 4'(sy));
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic [11:0] c, input logic p, input exp_t e);
      int n;
      n = 0;
      HAMM_IN = c; PARITY_IN = p; cur_exp = e; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", exp_q.size(), 0);
      idle(2);
   endtask

   // Random backpressure and counter clears, away from the driver's update time.
   initial begin
      forever begin
         @(posedge clk); #2;
         if (rand_mode) begin
            out_ready = ($urandom_range(0, 9) < 7);
            clr_cnt   = ($urandom_range(0, 19) == 0);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_sec = 0; m_ded = 0; stall_prev = 0;
      end else begin
         chk("cnt_sec", cnt_sec, m_sec);
         chk("cnt_ded", cnt_ded, m_ded);
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_out", OUT, sv_out);
            chk("hold_sec", sec_err, sv_sec);
            chk("hold_ded", ded_err, sv_ded);
            chk("hold_syn", syndrome, sv_syn);
         end
         if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", out_valid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out", OUT, mon_e.dat);
               chk("sec_err", sec_err, mon_e.sec);
               chk("ded_err", ded_err, mon_e.ded);
               chk("syndrome", syndrome, mon_e.syn);
               if (!clr_cnt) begin
                  if (mon_e.sec) m_sec = (m_sec + 1 > MAXC) ? MAXC : m_sec + 1;
                  if (mon_e.ded) m_ded = (m_ded + 1 > MAXC) ? MAXC : m_ded + 1;
               end
            end
         end
         if (clr_cnt) begin
            m_sec = 0; m_ded = 0;
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
         stall_prev = out_valid && !out_ready;
         sv_out = OUT; sv_sec = sec_err; sv_ded = ded_err; sv_syn = syndrome;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [11:0] c;
      logic        p;
      exp_t        e;

      rst_n = 1'b0; in_valid = 1'b0; HAMM_IN = '0; PARITY_IN = 1'b0;
      out_ready = 1'b1; clr_cnt = 1'b0; cur_exp = '0;
      idle(3);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", OUT, 0);
      chk("rst_sec", sec_err, 0);
      chk("rst_ded", ded_err, 0);
      chk("rst_syn", syndrome, 0);
      chk("rst_cnt_sec", cnt_sec, 0);
      chk("rst_cnt_ded", cnt_ded, 0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", in_ready, 1);
      idle(1);

      // Clean word and exact latency.
      send(12'hC21, 1'b0, mk(8'hC4, 0, 0, 4'd0));
      chk("lat_not_early", out_valid, 0);
      idle(1);
      chk("lat_valid", out_valid, 1);
      chk("lat_out", OUT, 8'hC4);
      idle(2);

      // Single data error, parity-bit error, double error.
      send(12'hC01, 1'b0, mk(8'hC4, 1, 0, 4'd6));
      idle(3);
      chk("cnt_sec_one", cnt_sec, 1);
      send(12'hC21, 1'b1, mk(8'hC4, 1, 0, 4'd0));
      send(12'h801, 1'b0, mk(8'h80, 0, 1, 4'd13));
      idle(3);
      chk("cnt_ded_one", cnt_ded, 1);

      // Back-to-back stream of 4 clean words with a 3-cycle stall mid-stream.
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               e = mk(8'($urandom), 0, 0, 4'd0);
               c = m_encode(e.dat);
               send(c, ^c, e);
            end
         end
         begin
            idle(2);
            out_ready = 1'b0;
            idle(3);
            out_ready = 1'b1;
         end
      join
      drain();

      // Clear coinciding with an SEC handshake.
      send(12'hC01, 1'b0, mk(8'hC4, 1, 0, 4'd6));
      idle(1);
      chk("clr_pre_valid", out_valid, 1);
      clr_cnt = 1'b1;
      idle(1);
      clr_cnt = 1'b0;
      chk("clr_wins", cnt_sec, 0);
      drain();

      // Randomized traffic.
      rand_mode = 1;
      for (int i = 0; i < 500; i++) begin
         gen_rand(c, p, e);
         send(c, p, e);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_mode = 0;
      idle(1);
      out_ready = 1'b1; clr_cnt = 1'b0;
      drain();

      // Drive cnt_sec into saturation.
      for (int i = 0; i < MAXC + 4; i++) begin
         send(12'hC01, 1'b0, mk(8'hC4, 1, 0, 4'd6));
      end
      drain();
      chk("sat_cnt_sec", cnt_sec, 16'hFFFF);

      // Reset while a word is in flight and held.
      out_ready = 1'b0;
      send(12'hC21, 1'b0, mk(8'hC4, 0, 0, 4'd0));
      idle(1);
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cnt_sec", cnt_sec, 0);
      out_ready = 1'b1;
      idle(2);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("no_partial", out_valid, 0);
      end
      send(12'hC01, 1'b0, mk(8'hC4, 1, 0, 4'd6));
      drain();
      chk("post_rst_cnt_sec", cnt_sec, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
